// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor: processes BW-bit operands CW bits per clock,
// LSB slice first, with the inter-slice carry held in a register.
module chunked_addsub #(
   parameter int BW = 16,
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [BW-1:0] a,
   input  logic [BW-1:0] b,
   input  logic          cin,
   input  logic          sub,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [BW-1:0] sum,
   output logic          cout,
   output logic          ovf,
   output logic          busy
);

   localparam int NCHUNK = BW / CW;
   localparam int CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CNTW-1:0] LAST = CNTW'(NCHUNK - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q;
   logic [CNTW-1:0] cnt_q;
   logic            carry_q;
   logic [BW-1:0]   opa_q;
   logic [BW-1:0]   opb_q;
   logic [CW-1:0]   res_q [NCHUNK];
   logic            cout_q;
   logic            ovf_q;

   logic [CW-1:0]   opa_slice [NCHUNK];
   logic [CW-1:0]   opb_slice [NCHUNK];
   logic [CW:0]     slice_d;

   genvar gi;
   generate
      for (gi = 0; gi < NCHUNK; gi++) begin : g_slice
         assign opa_slice[gi]          = opa_q[gi*CW +: CW];
         assign opb_slice[gi]          = opb_q[gi*CW +: CW];
         assign sum[gi*CW +: CW]       = res_q[gi];
      end
   endgenerate

   assign slice_d = {1'b0, opa_slice[cnt_q]} + {1'b0, opb_slice[cnt_q]}
                  + {{CW{1'b0}}, carry_q};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         for (int i = 0; i < NCHUNK; i++) res_q[i] <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  // Subtraction is A + ~B + ~borrow, so B and the carry are inverted here.
                  opa_q   <= a;
                  opb_q   <= sub ? ~b : b;
                  carry_q <= sub ? ~cin : cin;
                  cnt_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               res_q[cnt_q] <= slice_d[CW-1:0];
               carry_q      <= slice_d[CW];
               if (cnt_q == LAST) begin
                  cout_q  <= slice_d[CW];
                  ovf_q   <= (opa_q[BW-1] == opb_q[BW-1]) &&
                             (slice_d[CW-1] != opa_q[BW-1]);
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = rst_n && (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Directed scoreboard bench for chunked_addsub in three configurations.
module tb_chunked_addsub;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // default configuration BW=16, CW=4
   logic        rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, busy;
   logic [15:0] a, b, sum;

   chunked_addsub #(.BW(16), .CW(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
   );

   // two 8-bit configurations sharing operands, run in lockstep
   logic       in_valid8, out_ready8, cin8, sub8;
   logic [7:0] a8, b8;
   logic       rdy_w, val_w, cout_w, ovf_w, busy_w;
   logic       rdy_n, val_n, cout_n, ovf_n, busy_n;
   logic [7:0] sum_w, sum_n;

   chunked_addsub #(.BW(8), .CW(8)) dut_w (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(rdy_w),
      .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(val_w),
      .out_ready(out_ready8), .sum(sum_w), .cout(cout_w), .ovf(ovf_w), .busy(busy_w)
   );

   chunked_addsub #(.BW(8), .CW(1)) dut_n (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(rdy_n),
      .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(val_n),
      .out_ready(out_ready8), .sum(sum_n), .cout(cout_n), .ovf(ovf_n), .busy(busy_n)
   );

   logic [33:0] sb16 [$];
   logic [33:0] sb8w [$];
   logic [33:0] sb8n [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: {ovf, cout, sum} computed with whole-word arithmetic of width w.
   function automatic logic [33:0] model(input int w, input logic [31:0] ma, mb,
                                         input logic mcin, msub);
      logic [32:0] mask, tot, bb;
      logic [31:0] s;
      logic        c, sa, sb_, ss, o;
      mask = (33'h1 << w) - 1;
      bb   = msub ? (~{1'b0, mb}) & mask : {1'b0, mb} & mask;
      tot  = ({1'b0, ma} & mask) + bb + (msub ? {32'b0, ~mcin} : {32'b0, mcin});
      s    = tot[31:0] & mask[31:0];
      c    = tot[w];
      sa   = ma[w-1];
      sb_  = mb[w-1];
      ss   = s[w-1];
      o    = msub ? ((sa != sb_) && (ss != sa)) : ((sa == sb_) && (ss != sa));
      return {o, c, s};
   endfunction

   task automatic op16(input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic tcin, input logic tsub, input int hold);
      int n;
      logic [33:0] e;
      logic [15:0] s0;
      a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
      check("accept_ready", in_ready, 1);
      sb16.push_back(model(16, ta, tb_v, tcin, tsub));
      @(posedge clk); #1;
      in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
      n = 0;
      while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
      check("latency16", n, 4);
      e = sb16.pop_front();
      check("sum16", sum, e[15:0]);
      check("cout16", cout, e[32]);
      check("ovf16", ovf, e[33]);
      $display("txn16 a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b", ta, tb_v, tcin, tsub, sum, cout, ovf);
      s0 = sum;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
         @(posedge clk); #1;
         check("hold_valid", out_valid, 1);
         check("hold_sum", sum, s0);
         check("hold_cout", cout, e[32]);
         check("hold_ovf", ovf, e[33]);
         check("hold_ready", in_ready, 0);
         check("hold_busy", busy, 1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("post_valid", out_valid, 0);
      check("post_ready", in_ready, 1);
      check("post_busy", busy, 0);
      check("post_sum_kept", sum, s0);
   endtask

   task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v);
      int n, lw, ln;
      logic [33:0] e;
      a8 = ta; b8 = tb_v; cin8 = 1'b0; sub8 = 1'b0; in_valid8 = 1'b1;
      #0;
      check("rdy8w", rdy_w, 1);
      check("rdy8n", rdy_n, 1);
      sb8w.push_back(model(8, {24'b0, ta}, {24'b0, tb_v}, 1'b0, 1'b0));
      sb8n.push_back(model(8, {24'b0, ta}, {24'b0, tb_v}, 1'b0, 1'b0));
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      n = 0; lw = -1; ln = -1;
      while ((lw < 0 || ln < 0) && n < 30) begin
         if (val_w && lw < 0) lw = n;
         if (val_n && ln < 0) ln = n;
         if (lw < 0 || ln < 0) begin @(posedge clk); #1; n++; end
      end
      check("latency8w", lw, 1);
      check("latency8n", ln, 8);
      e = sb8w.pop_front();
      check("sum8w", sum_w, e[7:0]);
      check("cout8w", cout_w, e[32]);
      check("ovf8w", ovf_w, e[33]);
      e = sb8n.pop_front();
      check("sum8n", sum_n, e[7:0]);
      check("cout8n", cout_n, e[32]);
      check("ovf8n", ovf_n, e[33]);
      $display("txn8 a=%h b=%h -> w:sum=%h cout=%b ovf=%b n:sum=%h cout=%b ovf=%b",
               ta, tb_v, sum_w, cout_w, ovf_w, sum_n, cout_n, ovf_n);
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", in_ready, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);
      rst_n = 1'b1; #1;
      check("rel_ready", in_ready, 1);

      op16(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
      op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
      op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
      op16(16'h00FF, 16'h0000, 1'b1, 1'b0, 0);
      op16(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
      op16(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
      op16(16'h0010, 16'h0000, 1'b1, 1'b1, 0);
      op16(16'h9876, 16'hABCD, 1'b1, 1'b0, 5);
      op16(16'h4000, 16'hC001, 1'b0, 1'b1, 0);

      // abort mid-operation after two slices have been processed
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
      sb16.push_back(model(16, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0));
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mid_busy", busy, 1);
      rst_n = 1'b0;
      sb16.delete();
      @(posedge clk); #1;
      check("abort_valid", out_valid, 0);
      check("abort_sum", sum, 0);
      check("abort_busy", busy, 0);
      check("abort_ready_in_rst", in_ready, 0);
      rst_n = 1'b1; #1;
      check("abort_ready", in_ready, 1);
      op16(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

      op8(8'h80, 8'h80);
      op8(8'hAA, 8'h55);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
